// File: rtl/key_pkg.sv
// Shared constants and helpers for the key event arbiter slice.
package key_pkg;

   localparam int KEY_NUM_DEF    = 4;
   localparam int FIFO_DEPTH_DEF = 4;

   // Ceiling log2, evaluated at elaboration time for widths.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int w = 0; w < 31; w++) begin
         if ((1 << w) < value) result = w + 1;
      end
      return result;
   endfunction

   localparam int CODE_W_DEF = clog2(KEY_NUM_DEF);

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on dout while not empty.
module key_evt_fifo
   import key_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int WIDTH = CODE_W_DEF
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic [clog2(DEPTH):0] count,
   output logic                  empty,
   output logic                  full
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge sys_clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/key_event_arbiter.sv
// Latches key press pulses, grants them round-robin and queues key indices.
module key_event_arbiter
   import key_pkg::*;
#(
   parameter int KEY_NUM    = KEY_NUM_DEF,
   parameter int CODE_W     = clog2(KEY_NUM),
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [KEY_NUM-1:0] key_flag,
   input  logic               evt_ready,
   output logic               evt_valid,
   output logic [CODE_W-1:0]  evt_code,
   output logic               evt_overflow
);

   localparam int                CNT_W    = clog2(FIFO_DEPTH) + 1;
   localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(KEY_NUM - 1);

   logic [KEY_NUM-1:0] pending;
   logic [CODE_W-1:0]  rr_ptr;
   logic               grant_valid;
   logic [CODE_W-1:0]  grant_idx;
   logic [KEY_NUM-1:0] grant_vec;
   logic [CODE_W-1:0]  cand_idx;
   int                 cand;
   logic               fifo_full;
   logic               fifo_empty;
   logic               evt_pop;
   logic [CNT_W-1:0]   fifo_count;
   logic               unused_fifo_count;

   // Scan from the highest offset down so the nearest pending key above rr_ptr wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      if (!fifo_full && pending != '0) begin
         for (int k = KEY_NUM - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= KEY_NUM) cand = cand - KEY_NUM;
            cand_idx = CODE_W'(cand);
            if (pending[cand_idx]) begin
               grant_valid = 1'b1;
               grant_idx   = cand_idx;
            end
         end
      end
   end

   assign grant_vec = grant_valid ? (KEY_NUM'(1) << grant_idx) : '0;
   assign evt_valid = ~fifo_empty;
   assign evt_pop   = ~fifo_empty & evt_ready;

   // A press landing on an ungranted pending bit cannot be held and is reported.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pending      <= '0;
         rr_ptr       <= '0;
         evt_overflow <= 1'b0;
      end else begin
         pending      <= (pending & ~grant_vec) | key_flag;
         evt_overflow <= |(key_flag & pending & ~grant_vec);
         if (grant_valid) rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
   end

   key_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CODE_W)
   ) u_evt_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .push      (grant_valid),
      .din       (grant_idx),
      .pop       (evt_pop),
      .dout      (evt_code),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign unused_fifo_count = ^fifo_count;

endmodule
